// File: rtl/arbiter_wrr_qos.sv
// Round-robin / weighted round-robin arbiter with owner lock and registered one-hot grant.
// Optional macro ARB_LOCK_TIMEOUT_EN bounds LOCK to LOCK_MAX cycles and pulses o_lock_err on release.
module arbiter_wrr_qos #(
  parameter int unsigned NUM_CLIENTS  = 4,
  parameter int unsigned WEIGHT_WIDTH = 4,
  parameter int unsigned LOCK_MAX     = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CLIENTS-1:0]              i_req,
  input  logic [NUM_CLIENTS-1:0]              i_lock,
  input  logic [NUM_CLIENTS-1:0]              i_mask,
  input  logic                                i_mode,
  input  logic [NUM_CLIENTS*WEIGHT_WIDTH-1:0] i_weight,
  output logic [NUM_CLIENTS-1:0]              o_gnt,
  output logic [$clog2(NUM_CLIENTS)-1:0]      o_gnt_id,
  output logic                                o_gnt_vld,
  output logic                                o_lock_err
);
  localparam int unsigned ID_W = $clog2(NUM_CLIENTS);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, LOCK = 2'd2} state_t;

  state_t                  state, state_d;
  logic [ID_W-1:0]         owner_d, last_ptr, ptr_d, winner;
  logic [WEIGHT_WIDTH-1:0] credit, credit_d, win_weight;
  logic [NUM_CLIENTS-1:0]  elig, gnt_d;
  logic                    found, rotate;
  logic                    own_req, own_lock, own_mask;
  int unsigned             search_idx;

`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
  logic [CNT_W-1:0] lock_cnt, cnt_d;
  logic             forced;
`endif

  assign elig     = i_req & ~i_mask;
  assign own_req  = i_req[o_gnt_id];
  assign own_lock = i_lock[o_gnt_id];
  assign own_mask = i_mask[o_gnt_id];

  // First eligible client after last_ptr, wrapping; the last probe is last_ptr itself.
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    search_idx = 0;
    for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
      search_idx = (32'(last_ptr) + k) % NUM_CLIENTS;
      if (!found && elig[search_idx]) begin
        found  = 1'b1;
        winner = ID_W'(search_idx);
      end
    end
    win_weight = i_weight[32'(winner)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  end

  // Next-state: hold, lock, spend credit, or hand the grant on.
  always_comb begin
    state_d  = state;
    owner_d  = o_gnt_id;
    ptr_d    = last_ptr;
    credit_d = credit;
    rotate   = 1'b0;
`ifdef ARB_LOCK_TIMEOUT_EN
    cnt_d    = '0;
    forced   = 1'b0;
`endif
    case (state)
      IDLE: rotate = 1'b1;
      GRANT: begin
        if (own_req && own_lock) begin
          state_d = LOCK;
        end else if (own_req && !own_mask && credit != '0) begin
          credit_d = credit - WEIGHT_WIDTH'(1);
        end else begin
          rotate = 1'b1;
        end
      end
      LOCK: begin
        if (own_req && own_lock) begin
`ifdef ARB_LOCK_TIMEOUT_EN
          if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
            forced = 1'b1;
            rotate = 1'b1;
          end else begin
            cnt_d = lock_cnt + CNT_W'(1);
          end
`endif
        end else if (own_req) begin
          state_d = GRANT;
        end else begin
          rotate = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rotate) begin
      state_d = found ? GRANT : IDLE;
      if (found) begin
        owner_d  = winner;
        ptr_d    = winner;
        credit_d = i_mode ? win_weight : '0;
      end
    end
  end

  // Output decode of the upcoming owner, registered below.
  always_comb begin
    gnt_d = '0;
    if (state_d != IDLE) gnt_d[owner_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      credit    <= '0;
      last_ptr  <= ID_W'(NUM_CLIENTS - 1);
      o_gnt     <= '0;
      o_gnt_id  <= '0;
      o_gnt_vld <= 1'b0;
    end else begin
      state     <= state_d;
      credit    <= credit_d;
      last_ptr  <= ptr_d;
      o_gnt     <= gnt_d;
      o_gnt_id  <= owner_d;
      o_gnt_vld <= |gnt_d;
    end
  end

`ifdef ARB_LOCK_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt   <= '0;
      o_lock_err <= 1'b0;
    end else begin
      lock_cnt   <= cnt_d;
      o_lock_err <= forced;
    end
  end
`else
  assign o_lock_err = 1'b0;
  // LOCK_MAX only matters for the timeout build.
  logic [15:0] unused_lock_max;
  assign unused_lock_max = 16'(LOCK_MAX);
`endif

endmodule

// File: tb/tb_arbiter_wrr_qos.sv
// Scoreboard bench for arbiter_wrr_qos: directed scenarios plus random traffic against a queue-based model.
module tb_arbiter_wrr_qos;
  localparam int N    = 4;
  localparam int LMAX = 4;
`ifdef ARB_LOCK_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] id;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0, lock = '0, mask = '0;
  logic        mode = 1'b0;
  logic [15:0] weight = '0;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        gnt_vld, lock_err;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  logic [3:0] tr_gnt[$];
  logic       tr_err[$];
  bit trace_on = 1'b0;

  // Reference model: owner index (-1 = none), remaining credit, lock flag and lock run length.
  int m_owner = -1, m_credit = 0, m_run = 0, m_last = N - 1;
  bit m_lock = 1'b0;

  arbiter_wrr_qos #(.NUM_CLIENTS(4), .WEIGHT_WIDTH(4), .LOCK_MAX(LMAX)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_lock(lock), .i_mask(mask), .i_mode(mode),
    .i_weight(weight), .o_gnt(gnt), .o_gnt_id(gnt_id), .o_gnt_vld(gnt_vld), .o_lock_err(lock_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  function automatic int wsel(input logic [15:0] w, input int k);
    return int'((w >> (4 * k)) & 16'hF);
  endfunction

  task automatic model_step(input logic r, output exp_t e);
    bit lose, err;
    int o, c;
    lose = 1'b0;
    err  = 1'b0;
    if (r) begin
      m_owner = -1; m_credit = 0; m_run = 0; m_last = N - 1; m_lock = 1'b0;
    end else begin
      o = m_owner;
      if (o < 0) begin
        lose = 1'b1;
      end else if (m_lock) begin
        if (req[o] && lock[o]) begin
          m_run++;
          if (TMO && m_run >= LMAX) begin lose = 1'b1; err = 1'b1; end
        end else if (req[o]) begin
          m_lock = 1'b0;
        end else begin
          lose = 1'b1;
        end
      end else if (req[o] && lock[o]) begin
        m_lock = 1'b1; m_run = 0;
      end else if (req[o] && !mask[o] && m_credit > 0) begin
        m_credit--;
      end else begin
        lose = 1'b1;
      end
      if (lose) begin
        m_lock = 1'b0; m_run = 0; m_owner = -1;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (m_owner < 0 && req[c] && !mask[c]) begin
            m_owner  = c;
            m_last   = c;
            m_credit = mode ? wsel(weight, c) : 0;
          end
        end
      end
    end
    e.gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    e.vld = (m_owner >= 0);
    e.id  = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.err = err;
  endtask

  // One clock of stimulus: drive at the falling edge, predict the next rising edge.
  task automatic cyc(input logic [3:0] rq, input logic [3:0] lk, input logic [3:0] mk,
                     input logic md, input logic [15:0] wt, input logic r, input bit tr);
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; lock = lk; mask = mk; mode = md; weight = wt;
    trace_on = tr;
    model_step(r, e);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    cyc(4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    cyc(4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic check_trace(input string nm, input logic [3:0] eg[$], input logic ee[$]);
    @(posedge clk);
    #2;
    trace_on = 1'b0;
    chk({nm, "_len"}, 32'(tr_gnt.size()), 32'(eg.size()));
    if (tr_gnt.size() == eg.size()) begin
      foreach (eg[i]) begin
        chk($sformatf("%s_gnt[%0d]", nm, i), 32'(tr_gnt[i]), 32'(eg[i]));
        chk($sformatf("%s_err[%0d]", nm, i), 32'(tr_err[i]), 32'(ee[i]));
      end
    end
    tr_gnt.delete();
    tr_err.delete();
  endtask

  // Monitor: one expected entry per rising edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (trace_on) begin
          tr_gnt.push_back(gnt);
          tr_err.push_back(lock_err);
        end
        chk("sb_gnt", 32'(gnt), 32'(e.gnt));
        chk("sb_vld", 32'(gnt_vld), 32'(e.vld));
        chk("sb_err", 32'(lock_err), 32'(e.err));
        if (e.vld) chk("sb_id", 32'(gnt_id), 32'(e.id));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] eg[$];
    logic       ee[$];
    int         hold[4];
    logic [3:0] rq, lk, mk;
    hold = '{3, 2, 1, 4};
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_vld", 32'(gnt_vld), 32'h0);
    chk("rst_id", 32'(gnt_id), 32'h0);
    chk("rst_err", 32'(lock_err), 32'h0);

    // Plain round-robin, one cycle each.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(4'hF, 4'h0, 4'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    eg = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    ee = '{0, 0, 0, 0, 0};
    check_trace("rr", eg, ee);

    // Weighted: client k holds weight+1 cycles.
    do_reset();
    for (int i = 0; i < 20; i++) cyc(4'hF, 4'h0, 4'h0, 1'b1, 16'h3012, 1'b0, 1'b1);
    eg.delete(); ee.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        for (int h = 0; h < hold[c]; h++) begin eg.push_back(4'(1 << c)); ee.push_back(1'b0); end
    check_trace("wrr", eg, ee);

    // Client 1 locks for 10 cycles (client 2 lock is ignored while not owner).
    do_reset();
    for (int i = 0; i < 4; i++) cyc(4'hF, 4'h0, 4'h0, 1'b1, 16'h3012, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(4'hF, 4'h6, 4'h0, 1'b1, 16'h3012, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(4'hF, 4'h0, 4'h0, 1'b1, 16'h3012, 1'b0, 1'b1);
    eg.delete(); ee.delete();
    if (TMO) begin
      for (int i = 0; i < 4; i++) begin eg.push_back(4'h2); ee.push_back(1'b0); end
      for (int i = 0; i < 5; i++) begin eg.push_back(4'h4); ee.push_back(i == 0); end
      for (int i = 0; i < 4; i++) begin eg.push_back(4'h8); ee.push_back(i == 0); end
    end else begin
      for (int i = 0; i < 12; i++) begin eg.push_back(4'h2); ee.push_back(1'b0); end
      eg.push_back(4'h4); ee.push_back(1'b0);
    end
    check_trace("lock10", eg, ee);

    // Held lock on client 0: bounded only in the timeout build.
    do_reset();
    for (int i = 0; i < 7; i++) cyc(4'hF, 4'h1, 4'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    if (TMO) begin
      eg = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h4};
      ee = '{0, 0, 0, 0, 0, 1, 0};
    end else begin
      eg = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
      ee = '{0, 0, 0, 0, 0, 0, 0};
    end
    check_trace("lockhold", eg, ee);

    // Masking the unlocked owner, then masking everyone.
    do_reset();
    cyc(4'hF, 4'h0, 4'h0, 1'b1, 16'h3012, 1'b0, 1'b1);
    cyc(4'hF, 4'h0, 4'h1, 1'b1, 16'h3012, 1'b0, 1'b1);
    cyc(4'hF, 4'h0, 4'hF, 1'b1, 16'h3012, 1'b0, 1'b1);
    cyc(4'hF, 4'h0, 4'hF, 1'b1, 16'h3012, 1'b0, 1'b1);
    eg = '{4'h1, 4'h2, 4'h0, 4'h0};
    ee = '{0, 0, 0, 0};
    check_trace("mask", eg, ee);

    // Reset during LOCK drops the grant at once; client 0 is searched first afterwards.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(4'hF, 4'h1, 4'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(4'hF, 4'h1, 4'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    #1;
    chk("rstlock_gnt", 32'(gnt), 32'h0);
    chk("rstlock_vld", 32'(gnt_vld), 32'h0);
    chk("rstlock_err", 32'(lock_err), 32'h0);
    cyc(4'hF, 4'h0, 4'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    eg = '{4'h1};
    ee = '{0};
    check_trace("rstlock", eg, ee);

    // Random traffic with sticky request/lock/mask levels.
    do_reset();
    rq = 4'hF; lk = 4'h0; mk = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
        if ($urandom_range(0, 5) == 0) lk[b] = ~lk[b];
        if ($urandom_range(0, 9) == 0) mk[b] = ~mk[b];
      end
      cyc(rq, lk, mk, 1'($urandom_range(0, 1)), 16'($urandom()),
          1'($urandom_range(0, 299) == 0), 1'b0);
    end
    cyc(4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
